// File: rtl/alu_muldiv.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : alu_muldiv                                                       |
// | Purpose : Handshaked execute-stage unit. Base integer ops finish in one    |
// |           cycle; M-extension multiply/divide/remainder run on an           |
// |           iterative radix-2 datapath taking XLEN cycles.                   |
// | Ports   : clk, rst            clock, synchronous active-high reset         |
// |           in_valid/in_ready   request handshake                            |
// |           muldiv,funct3,alt   opcode select                                |
// |           a, b                operands                                     |
// |           out_valid/out_ready result handshake                             |
// |           result              registered result                            |
// |           busy                iterative operation in progress              |
// | Revision: 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module alu_muldiv #(
  parameter int XLEN = 32,
  parameter int SHW  = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            muldiv,
  input  logic [2:0]      funct3,
  input  logic            alt,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            busy
);

  localparam int              CW      = $clog2(XLEN) + 1;
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              state_q;
  logic [2*XLEN-1:0]   acc_q;     // {hi, lo}: product or {remainder, quotient}
  logic [XLEN-1:0]     opb_q;     // multiplicand / divisor magnitude
  logic [CW-1:0]       cnt_q;
  logic [2:0]          op_q;
  logic                neg_q;     // product or quotient needs negation
  logic                rneg_q;    // remainder needs negation
  logic [XLEN-1:0]     result_q;
  logic                out_valid_q;
  logic                busy_q;

  logic                accept;
  logic [XLEN-1:0]     alu_res_d;
  logic                a_signed, b_signed, a_neg, b_neg;
  logic [XLEN-1:0]     a_mag, b_mag;
  logic                div_zero, div_ovf;
  logic [XLEN-1:0]     special_res_d;
  logic [XLEN:0]       mul_sum;
  logic [XLEN:0]       div_shl, div_trial;
  logic [2*XLEN-1:0]   acc_d;
  logic [2*XLEN-1:0]   prod;
  logic [XLEN-1:0]     quo, rem;
  logic [XLEN-1:0]     calc_res_d;

  assign in_ready  = (state_q == IDLE) || ((state_q == DONE) && out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign busy      = busy_q;

  // Single-cycle base ALU
  always_comb begin
    alu_res_d = '0;
    case (funct3)
      3'd0: alu_res_d = alt ? (a - b) : (a + b);
      3'd1: alu_res_d = a << b[SHW-1:0];
      3'd2: alu_res_d = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
      3'd3: alu_res_d = {{(XLEN-1){1'b0}}, (a < b)};
      3'd4: alu_res_d = a ^ b;
      3'd5: alu_res_d = alt ? $unsigned($signed(a) >>> b[SHW-1:0]) : (a >> b[SHW-1:0]);
      3'd6: alu_res_d = a | b;
      default: alu_res_d = a & b;
    endcase
  end

  // Operand sign handling and special-case detection for M ops
  always_comb begin
    // MUL/MULH/DIV/REM: both signed; MULHSU: a only; MULHU/DIVU/REMU: neither
    a_signed = funct3[2] ? !funct3[0] : (funct3 != 3'd3);
    b_signed = funct3[2] ? !funct3[0] : !funct3[1];
    a_neg    = a_signed && a[XLEN-1];
    b_neg    = b_signed && b[XLEN-1];
    a_mag    = a_neg ? -a : a;
    b_mag    = b_neg ? -b : b;
    div_zero = funct3[2] && (b == '0);
    div_ovf  = funct3[2] && !funct3[0] && (a == MIN_NEG) && (b == '1);
    if (div_zero) special_res_d = funct3[1] ? a : '1;
    else          special_res_d = funct3[1] ? '0 : a;
  end

  // One iteration of shift-add multiply or restoring divide
  always_comb begin
    mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opb_q} : {(XLEN+1){1'b0}});
    div_shl   = acc_q[2*XLEN-1:XLEN-1];
    div_trial = div_shl - {1'b0, opb_q};
    acc_d     = acc_q;
    if (!op_q[2]) begin
      acc_d = {mul_sum, acc_q[XLEN-1:1]};
    end else if (!div_trial[XLEN]) begin
      // Trial subtraction did not borrow: keep difference, quotient bit 1
      acc_d = {div_trial[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
    end else begin
      acc_d = {div_shl[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
    end
  end

  // Sign correction of the finished iterative result
  always_comb begin
    prod = neg_q ? -acc_d : acc_d;
    quo  = acc_d[XLEN-1:0];
    rem  = acc_d[2*XLEN-1:XLEN];
    if (!op_q[2])     calc_res_d = (op_q == 3'd0) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    else if (op_q[1]) calc_res_d = rneg_q ? -rem : rem;
    else              calc_res_d = neg_q ? -quo : quo;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      opb_q       <= '0;
      cnt_q       <= '0;
      op_q        <= '0;
      neg_q       <= 1'b0;
      rneg_q      <= 1'b0;
      result_q    <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else if (accept) begin
      op_q <= funct3;
      if (!muldiv) begin
        result_q    <= alu_res_d;
        state_q     <= DONE;
        out_valid_q <= 1'b1;
        busy_q      <= 1'b0;
      end else if (div_zero || div_ovf) begin
        result_q    <= special_res_d;
        state_q     <= DONE;
        out_valid_q <= 1'b1;
        busy_q      <= 1'b0;
      end else begin
        state_q     <= CALC;
        out_valid_q <= 1'b0;
        busy_q      <= 1'b1;
        cnt_q       <= CW'(XLEN);
        acc_q       <= {{XLEN{1'b0}}, a_mag};
        opb_q       <= b_mag;
        neg_q       <= a_neg ^ b_neg;
        rneg_q      <= a_neg;
      end
    end else begin
      case (state_q)
        CALC: begin
          acc_q <= acc_d;
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            result_q    <= calc_res_d;
            state_q     <= DONE;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_muldiv.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_alu_muldiv                                                    |
// | Purpose : Self-checking bench for alu_muldiv (XLEN=32): directed cases,    |
// |           backpressure, mid-operation reset and randomized operations      |
// |           compared with a 64-bit arithmetic reference model.               |
// | Revision: 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module tb_alu_muldiv;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        muldiv;
  logic [2:0]  funct3;
  logic        alt;
  logic [31:0] a;
  logic [31:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        busy;

  int n_checks = 0;
  int n_pass   = 0;

  alu_muldiv #(.XLEN(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .muldiv   (muldiv),
    .funct3   (funct3),
    .alt      (alt),
    .a        (a),
    .b        (b),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result   (result),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Reference model: plain 64-bit arithmetic on the architectural definition
  function automatic logic [31:0] ref_model(input logic md, input logic [2:0] f3, input logic al,
                                            input logic [31:0] av, input logic [31:0] bv);
    longint sa, sb, ua, ub;
    logic [63:0] p;
    int sh;
    sa = longint'($signed(av));
    sb = longint'($signed(bv));
    ua = longint'({32'b0, av});
    ub = longint'({32'b0, bv});
    sh = int'(bv[4:0]);
    if (!md) begin
      case (f3)
        3'd0: return al ? av - bv : av + bv;
        3'd1: return av << sh;
        3'd2: return (sa < sb) ? 32'd1 : 32'd0;
        3'd3: return (ua < ub) ? 32'd1 : 32'd0;
        3'd4: return av ^ bv;
        3'd5: return al ? $unsigned($signed(av) >>> sh) : av >> sh;
        3'd6: return av | bv;
        default: return av & bv;
      endcase
    end
    case (f3)
      3'd0: begin p = 64'(sa * sb); return p[31:0]; end
      3'd1: begin p = 64'(sa * sb); return p[63:32]; end
      3'd2: begin p = 64'(sa * ub); return p[63:32]; end
      3'd3: begin p = 64'(ua * ub); return p[63:32]; end
      3'd4: begin
        if (bv == 32'd0) return 32'hFFFF_FFFF;
        if (av == 32'h8000_0000 && bv == 32'hFFFF_FFFF) return av;
        return 32'(sa / sb);
      end
      3'd5: return (bv == 32'd0) ? 32'hFFFF_FFFF : 32'(ua / ub);
      3'd6: begin
        if (bv == 32'd0) return av;
        if (av == 32'h8000_0000 && bv == 32'hFFFF_FFFF) return 32'd0;
        return 32'(sa % sb);
      end
      default: return (bv == 32'd0) ? av : 32'(ua % ub);
    endcase
  endfunction

  function automatic logic is_special(input logic md, input logic [2:0] f3,
                                      input logic [31:0] av, input logic [31:0] bv);
    return md && f3[2] && ((bv == 32'd0) ||
           (!f3[0] && av == 32'h8000_0000 && bv == 32'hFFFF_FFFF));
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  // Issue one op with out_ready=1, scramble inputs after accept, and check
  // latency, busy/in_ready during iteration and the result.
  task automatic run_op(input string tag, input logic md, input logic [2:0] f3, input logic al,
                        input logic [31:0] av, input logic [31:0] bv, input logic [31:0] exp);
    int   exp_lat;
    int   lat;
    logic calc_ok;
    exp_lat = (md && !is_special(md, f3, av, bv)) ? 33 : 1;
    @(negedge clk);
    muldiv = md; funct3 = f3; alt = al; a = av; b = bv;
    in_valid = 1'b1; out_ready = 1'b1;
    #1;
    check({tag, ".in_ready"}, 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = $urandom; b = $urandom; funct3 = 3'($urandom); muldiv = 1'($urandom); alt = 1'($urandom);
    lat = 1;
    calc_ok = 1'b1;
    while (!out_valid && lat < 40) begin
      if (busy !== 1'b1 || in_ready !== 1'b0) calc_ok = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    check({tag, ".latency"}, 32'(lat), 32'(exp_lat));
    check({tag, ".result"}, result, exp);
    check({tag, ".busy_at_done"}, 32'(busy), 32'd0);
    if (exp_lat > 1) check({tag, ".calc_busy"}, 32'(calc_ok), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic        md, al;
    logic [2:0]  f3;
    logic [31:0] av, bv;
    int          lat;

    rst = 1'b1; in_valid = 1'b0; muldiv = 1'b0; funct3 = 3'd0; alt = 1'b0;
    a = '0; b = '0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset.out_valid", 32'(out_valid), 32'd0);
    check("reset.busy", 32'(busy), 32'd0);
    check("reset.result", result, 32'd0);
    check("reset.in_ready", 32'(in_ready), 32'd1);
    @(negedge clk); rst = 1'b0;

    // Base ops and shift masking
    run_op("sub",   1'b0, 3'd0, 1'b1, 32'd5, 32'd7, 32'hFFFF_FFFE);
    run_op("sltu",  1'b0, 3'd3, 1'b0, 32'd1, 32'hFFFF_FFFF, 32'd1);
    run_op("slt",   1'b0, 3'd2, 1'b0, 32'd1, 32'hFFFF_FFFF, 32'd0);
    run_op("sra",   1'b0, 3'd5, 1'b1, 32'h8000_0000, 32'h24, 32'hF800_0000);
    run_op("srl",   1'b0, 3'd5, 1'b0, 32'h8000_0000, 32'h24, 32'h0800_0000);
    run_op("sll",   1'b0, 3'd1, 1'b0, 32'd1, 32'h3F, 32'h8000_0000);
    // Multiply variants
    run_op("mulh",   1'b1, 3'd1, 1'b0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000);
    run_op("mulhu",  1'b1, 3'd3, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    run_op("mulhsu", 1'b1, 3'd2, 1'b0, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF);
    run_op("mul",    1'b1, 3'd0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001);
    // Divide, divide by zero, overflow
    run_op("div",      1'b1, 3'd4, 1'b0, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
    run_op("rem",      1'b1, 3'd6, 1'b0, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
    run_op("div_zero", 1'b1, 3'd4, 1'b0, 32'd7, 32'd0, 32'hFFFF_FFFF);
    run_op("rem_zero", 1'b1, 3'd6, 1'b0, 32'd7, 32'd0, 32'd7);
    run_op("div_ovf",  1'b1, 3'd4, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
    run_op("rem_ovf",  1'b1, 3'd6, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);

    // Backpressure: DIVU 100/7 held, then four back-to-back ADDs
    @(negedge clk); in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    muldiv = 1'b1; funct3 = 3'd5; alt = 1'b0; a = 32'd100; b = 32'd7;
    in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check("bp.latency", 32'(lat), 32'd33);
    check("bp.result", result, 32'd14);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("bp.hold_result", result, 32'd14);
      check("bp.hold_valid", 32'(out_valid), 32'd1);
      check("bp.hold_in_ready", 32'(in_ready), 32'd0);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      out_ready = 1'b1; in_valid = 1'b1; muldiv = 1'b0; funct3 = 3'd0; alt = 1'b0;
      a = 32'(i * 1000 + 17); b = 32'(i + 5);
      #1;
      check("b2b.in_ready", 32'(in_ready), 32'd1);
      @(posedge clk); #1;
      check("b2b.out_valid", 32'(out_valid), 32'd1);
      check("b2b.result", result, 32'(i * 1000 + 17 + i + 5));
    end
    in_valid = 1'b0;

    // Reset in the middle of a DIV
    @(negedge clk);
    muldiv = 1'b1; funct3 = 3'd4; alt = 1'b0; a = 32'd100; b = 32'd3;
    in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    check("rst_mid.out_valid", 32'(out_valid), 32'd0);
    check("rst_mid.busy", 32'(busy), 32'd0);
    check("rst_mid.in_ready", 32'(in_ready), 32'd1);
    check("rst_mid.result", result, 32'd0);
    @(negedge clk); rst = 1'b0;
    run_op("rst_add", 1'b0, 3'd0, 1'b0, 32'd2, 32'd3, 32'd5);

    // Randomized operations against the reference model
    for (int i = 0; i < 80; i++) begin
      md = 1'($urandom);
      f3 = 3'($urandom);
      al = 1'($urandom);
      av = pick_operand();
      bv = pick_operand();
      run_op(md ? "rand_m" : "rand_base", md, f3, al, av, bv, ref_model(md, f3, al, av, bv));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
